// File: rtl/sd_pkg.sv
// Shared types and constants for the card-side SD CMD line endpoint.
package sd_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_R1   = 2'd1,
    RESP_R3   = 2'd2,
    RESP_R2   = 2'd3
  } resp_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_WAIT = 2'd2,
    ST_TX   = 2'd3
  } state_e;

  localparam int         CMD_FRAME_LEN = 48;
  localparam int         R2_FRAME_LEN  = 136;
  localparam logic [6:0] CRC7_POLY     = 7'h09;  // x^7 + x^3 + 1
  localparam logic [5:0] FIXED_INDEX   = 6'b111111;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Bit-serial CRC7; clear together with enable restarts the CRC with that bit.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       iclk,
  input  logic       irst_n,
  input  logic       iclr,
  input  logic       ien,
  input  logic       idin,
  output logic [6:0] ocrc
);

  logic [6:0] base;

  assign base = iclr ? 7'h00 : ocrc;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      ocrc <= 7'h00;
    end else if (ien) begin
      ocrc <= crc7_step(base, idin);
    end else if (iclr) begin
      ocrc <= 7'h00;
    end
  end

endmodule

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD endpoint: receives 48-bit commands, checks CRC7 and
// framing, then serialises an R1/R3/R2 response within the NCR window.
module sd_cmd_responder
  import sd_pkg::*;
#(
  parameter int NCR     = 2,
  parameter int NCR_MAX = 64
) (
  input  logic         iclk,
  input  logic         irst_n,
  input  logic         icmd_sd,
  output logic         ocmd_sd,
  output logic         ocmd_oe,
  output logic         ocmd_valid,
  output logic [5:0]   ocmd_index,
  output logic [31:0]  ocmd_arg,
  output logic         ocrc_err,
  output logic         otimeout,
  input  logic         iresp_valid,
  input  logic [1:0]   iresp_type,
  input  logic [126:0] iresp_data,
  output logic         obusy
);

  localparam logic [7:0] NCR_L       = 8'(NCR);
  localparam logic [7:0] NCR_MAX_L   = 8'(NCR_MAX);
  localparam logic [7:0] RX_LAST_BIT = 8'(CMD_FRAME_LEN - 1);
  localparam logic [7:0] CRC_FIRST   = 8'd40;
  localparam logic [7:0] CRC_LAST    = 8'd46;

  state_e         state;
  logic [7:0]     bit_cnt;
  logic           tx_started;
  logic           tx_is_r1;
  logic [7:0]     tx_len;
  logic [45:0]    rx_shift;
  logic [135:0]   tx_shift;
  logic [135:0]   frame_load;
  resp_type_e     resp_t;

  logic           rx_crc_clr;
  logic           rx_crc_en;
  logic [6:0]     rx_crc;
  logic           tx_crc_clr;
  logic           tx_crc_en;
  logic [6:0]     tx_crc;

  logic           frame_good;
  logic           accept;
  logic           tx_start;
  logic           tx_drive;
  logic           tx_bit;
  logic [2:0]     crc_sel;

  assign resp_t = resp_type_e'(iresp_type);
  assign obusy  = (state != ST_IDLE);

  // ---- receive: CRC covers start bit through the argument (bits 0..39)
  assign rx_crc_clr = (state == ST_IDLE) && !icmd_sd;
  assign rx_crc_en  = rx_crc_clr || ((state == ST_RX) && (bit_cnt < CRC_FIRST));

  sd_crc7 u_rx_crc (
    .iclk   (iclk),
    .irst_n (irst_n),
    .iclr   (rx_crc_clr),
    .ien    (rx_crc_en),
    .idin   (icmd_sd),
    .ocrc   (rx_crc)
  );

  // rx_shift holds frame bits 1..46 when the end bit is on the line
  assign frame_good = rx_shift[45] && (rx_shift[6:0] == rx_crc) && icmd_sd;

  // ---- response framing, MSB-first, left-aligned in the 136-bit register
  always_comb begin
    frame_load = '0;
    case (resp_t)
      RESP_R1: frame_load = {2'b00, ocmd_index,  iresp_data[31:0], 7'h7F, 1'b1, 88'd0};
      RESP_R3: frame_load = {2'b00, FIXED_INDEX, iresp_data[31:0], 7'h7F, 1'b1, 88'd0};
      RESP_R2: frame_load = {2'b00, FIXED_INDEX, iresp_data, 1'b1};
      default: frame_load = '0;
    endcase
  end

  assign accept   = (state == ST_WAIT) && iresp_valid && (resp_t != RESP_NONE);
  assign tx_start = (state == ST_TX) && !tx_started && (bit_cnt >= NCR_L);
  assign tx_drive = tx_start || ((state == ST_TX) && tx_started && (bit_cnt < tx_len));

  // ---- transmit: R1 CRC is generated on the fly from the first 40 bits sent
  assign tx_crc_clr = tx_start;
  assign tx_crc_en  = tx_start || ((state == ST_TX) && tx_started && (bit_cnt < CRC_FIRST));

  sd_crc7 u_tx_crc (
    .iclk   (iclk),
    .irst_n (irst_n),
    .iclr   (tx_crc_clr),
    .ien    (tx_crc_en),
    .idin   (tx_shift[135]),
    .ocrc   (tx_crc)
  );

  // bits 40..46 have low bits 0..6, so MSB-first selection is 6 - low bits
  assign crc_sel = 3'd6 - bit_cnt[2:0];
  assign tx_bit  = (tx_started && tx_is_r1 && (bit_cnt >= CRC_FIRST) && (bit_cnt <= CRC_LAST))
                   ? tx_crc[crc_sel] : tx_shift[135];

  // ---- datapath shift registers (contents are don't-care until framed)
  always_ff @(posedge iclk) begin
    if (rx_crc_clr || (state == ST_RX)) begin
      rx_shift <= {rx_shift[44:0], icmd_sd};
    end
    if (accept) begin
      tx_shift <= frame_load;
    end else if (tx_drive) begin
      tx_shift <= {tx_shift[134:0], 1'b0};
    end
  end

  // ---- control FSM; bit_cnt counts RX bits, WAIT edges after E, then TX bits
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= 8'd0;
      tx_started <= 1'b0;
      tx_is_r1   <= 1'b0;
      tx_len     <= 8'd0;
      ocmd_sd    <= 1'b1;
      ocmd_oe    <= 1'b0;
      ocmd_valid <= 1'b0;
      ocrc_err   <= 1'b0;
      otimeout   <= 1'b0;
      ocmd_index <= 6'd0;
      ocmd_arg   <= 32'd0;
    end else begin
      ocmd_valid <= 1'b0;
      ocrc_err   <= 1'b0;
      otimeout   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!icmd_sd) begin
            state   <= ST_RX;
            bit_cnt <= 8'd1;
          end
        end
        ST_RX: begin
          if (bit_cnt == RX_LAST_BIT) begin
            if (frame_good) begin
              ocmd_valid <= 1'b1;
              ocmd_index <= rx_shift[44:39];
              ocmd_arg   <= rx_shift[38:7];
              bit_cnt    <= 8'd1;
              state      <= ST_WAIT;
            end else begin
              ocrc_err <= 1'b1;
              state    <= ST_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end
        ST_WAIT: begin
          if (iresp_valid) begin
            if (resp_t == RESP_NONE) begin
              state <= ST_IDLE;
            end else begin
              state      <= ST_TX;
              tx_started <= 1'b0;
              tx_is_r1   <= (resp_t == RESP_R1);
              tx_len     <= (resp_t == RESP_R2) ? 8'(R2_FRAME_LEN) : 8'(CMD_FRAME_LEN);
              bit_cnt    <= bit_cnt + 8'd1;
            end
          end else if (bit_cnt == NCR_MAX_L) begin
            otimeout <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end
        ST_TX: begin
          if (!tx_started) begin
            if (bit_cnt >= NCR_L) begin
              tx_started <= 1'b1;
              ocmd_oe    <= 1'b1;
              ocmd_sd    <= tx_bit;
              bit_cnt    <= 8'd1;
            end else begin
              bit_cnt <= bit_cnt + 8'd1;
            end
          end else if (bit_cnt < tx_len) begin
            ocmd_sd <= tx_bit;
            bit_cnt <= bit_cnt + 8'd1;
          end else begin
            ocmd_oe    <= 1'b0;
            ocmd_sd    <= 1'b1;
            tx_started <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Self-checking bench for sd_cmd_responder: directed frames plus randomized
// commands/responses checked against a frame-level reference model.
module tb_sd_cmd_responder;

  localparam int NCR     = 2;
  localparam int NCR_MAX = 64;

  logic         iclk = 1'b0;
  logic         irst_n = 1'b0;
  logic         icmd_sd = 1'b1;
  logic         iresp_valid = 1'b0;
  logic [1:0]   iresp_type = 2'd0;
  logic [126:0] iresp_data = '0;
  logic         ocmd_sd;
  logic         ocmd_oe;
  logic         ocmd_valid;
  logic [5:0]   ocmd_index;
  logic [31:0]  ocmd_arg;
  logic         ocrc_err;
  logic         otimeout;
  logic         obusy;

  int errors = 0;
  int checks = 0;

  sd_cmd_responder #(.NCR(NCR), .NCR_MAX(NCR_MAX)) dut (
    .iclk        (iclk),
    .irst_n      (irst_n),
    .icmd_sd     (icmd_sd),
    .ocmd_sd     (ocmd_sd),
    .ocmd_oe     (ocmd_oe),
    .ocmd_valid  (ocmd_valid),
    .ocmd_index  (ocmd_index),
    .ocmd_arg    (ocmd_arg),
    .ocrc_err    (ocrc_err),
    .otimeout    (otimeout),
    .iresp_valid (iresp_valid),
    .iresp_type  (iresp_type),
    .iresp_data  (iresp_data),
    .obusy       (obusy)
  );

  always #5 iclk = ~iclk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge iclk);
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
    logic [46:0] v;
    v = {msg, 7'd0};
    for (int i = 46; i >= 7; i--) begin
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    end
    return v[6:0];
  endfunction

  function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] m;
    m = {2'b01, idx, arg};
    return {m, crc7_ref(m), 1'b1};
  endfunction

  function automatic logic [126:0] rand127();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[126:0];
  endfunction

  task automatic exp_resp(input logic [1:0] t, input logic [5:0] idx, input logic [126:0] data,
                          output logic [135:0] f, output int len);
    logic [39:0] m;
    f = '0;
    len = 0;
    case (t)
      2'd1: begin
        m = {2'b00, idx, data[31:0]};
        f = {m, crc7_ref(m), 1'b1, 88'd0};
        len = 48;
      end
      2'd2: begin
        f = {2'b00, 6'h3F, data[31:0], 7'h7F, 1'b1, 88'd0};
        len = 48;
      end
      2'd3: begin
        f = {2'b00, 6'h3F, data, 1'b1};
        len = 136;
      end
      default: ;
    endcase
  endtask

  // Drives a 48-bit frame MSB first; returns at the negedge after edge E.
  // iresp_valid toggles randomly meanwhile and must be ignored.
  task automatic send_cmd(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      icmd_sd     = f[i];
      iresp_valid = 1'($urandom_range(0, 1));
      iresp_type  = 2'($urandom_range(0, 3));
      step();
    end
    icmd_sd     = 1'b1;
    iresp_valid = 1'b0;
  endtask

  // Offers a response at edge E+d (d outside 1..NCR_MAX: never) and checks
  // the CMD line against the model until the DUT goes idle.
  task automatic respond(input string tag, input int d, input logic [1:0] t,
                         input logic [126:0] data, input logic [5:0] idx,
                         output logic [135:0] cap);
    logic [135:0] exp_f;
    int exp_len, s_k, rel_k, to_k, idle_k, n, exp_s;
    logic rel_sd;
    bit accepted;
    exp_resp(t, idx, data, exp_f, exp_len);
    cap = '0;
    s_k = -1; rel_k = -1; to_k = -1; idle_k = -1; n = 0; rel_sd = 1'b0;
    for (int k = 1; k <= 400 && idle_k < 0; k++) begin
      iresp_valid = (k == d);
      iresp_type  = t;
      iresp_data  = data;
      step();
      if (ocmd_oe) begin
        if (s_k < 0) s_k = k;
        if (n < 136) cap[135 - n] = ocmd_sd;
        n++;
      end else if (s_k >= 0 && rel_k < 0) begin
        rel_k  = k;
        rel_sd = ocmd_sd;
      end
      if (otimeout) to_k = k;
      if (!obusy) idle_k = k;
    end
    iresp_valid = 1'b0;
    accepted = (d >= 1) && (d <= NCR_MAX);
    if (!accepted) begin
      chk({tag, "_timeout_edge"}, 136'(to_k), 136'(NCR_MAX));
      chk({tag, "_idle_edge"}, 136'(idle_k), 136'(NCR_MAX));
      chk({tag, "_oe_cycles"}, 136'(n), 136'(0));
    end else if (t == 2'd0) begin
      chk({tag, "_idle_edge"}, 136'(idle_k), 136'(d));
      chk({tag, "_oe_cycles"}, 136'(n), 136'(0));
      chk({tag, "_no_timeout"}, 136'(to_k), 136'(-1));
    end else begin
      exp_s = (d + 1 > NCR) ? d + 1 : NCR;
      chk({tag, "_start_edge"}, 136'(s_k), 136'(exp_s));
      chk({tag, "_oe_cycles"}, 136'(n), 136'(exp_len));
      chk({tag, "_frame"}, cap, exp_f);
      chk({tag, "_release_edge"}, 136'(rel_k), 136'(exp_s + exp_len));
      chk({tag, "_release_sd"}, 136'(rel_sd), 136'(1));
      chk({tag, "_idle_edge"}, 136'(idle_k), 136'(exp_s + exp_len));
      chk({tag, "_no_timeout"}, 136'(to_k), 136'(-1));
    end
  endtask

  initial begin
    logic [135:0] cap;
    logic [47:0]  f;
    logic [5:0]   last_idx;
    logic [31:0]  last_arg;
    logic [126:0] r2_data;
    int           wait_n;

    // reset state
    step();
    step();
    chk("rst_oe", 136'(ocmd_oe), 136'(0));
    chk("rst_sd", 136'(ocmd_sd), 136'(1));
    chk("rst_valid", 136'(ocmd_valid), 136'(0));
    chk("rst_crc_err", 136'(ocrc_err), 136'(0));
    chk("rst_timeout", 136'(otimeout), 136'(0));
    chk("rst_index", 136'(ocmd_index), 136'(0));
    chk("rst_arg", 136'(ocmd_arg), 136'(0));
    chk("rst_busy", 136'(obusy), 136'(0));
    irst_n = 1'b1;
    step();
    step();
    chk("idle_busy", 136'(obusy), 136'(0));

    // CMD0, no response
    send_cmd(48'h40_0000_0000_95);
    chk("cmd0_valid", 136'(ocmd_valid), 136'(1));
    chk("cmd0_crc_err", 136'(ocrc_err), 136'(0));
    chk("cmd0_index", 136'(ocmd_index), 136'(0));
    chk("cmd0_arg", 136'(ocmd_arg), 136'(0));
    chk("cmd0_busy", 136'(obusy), 136'(1));
    respond("cmd0", 3, 2'd0, '0, 6'd0, cap);
    step();
    chk("cmd0_valid_pulse", 136'(ocmd_valid), 136'(0));

    // CMD8 with R1 offered immediately
    send_cmd(48'h48_0000_01AA_87);
    chk("cmd8_valid", 136'(ocmd_valid), 136'(1));
    chk("cmd8_index", 136'(ocmd_index), 136'(8));
    chk("cmd8_arg", 136'(ocmd_arg), 136'(32'h1AA));
    respond("cmd8", 1, 2'd1, 127'h1AA, 6'd8, cap);
    chk("cmd8_hdr", 136'(cap[135:96]), 136'(40'h08_0000_01AA));

    // CMD17, R1 status offered at E+10
    send_cmd(48'h51_0000_0000_55);
    chk("cmd17_valid", 136'(ocmd_valid), 136'(1));
    chk("cmd17_index", 136'(ocmd_index), 136'(17));
    respond("cmd17", 10, 2'd1, 127'h900, 6'd17, cap);
    chk("cmd17_resp", 136'(cap[135:88]), 136'(48'h11_0000_0900_67));

    // CMD17 with one argument bit flipped
    send_cmd(48'h51_0000_0000_55 ^ 48'h00_0010_0000_00);
    chk("bad_crc_err", 136'(ocrc_err), 136'(1));
    chk("bad_valid", 136'(ocmd_valid), 136'(0));
    chk("bad_index_held", 136'(ocmd_index), 136'(17));
    iresp_valid = 1'b1;
    iresp_type  = 2'd1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("bad_oe", 136'(ocmd_oe), 136'(0));
    end
    iresp_valid = 1'b0;
    chk("bad_busy", 136'(obusy), 136'(0));
    chk("bad_err_pulse", 136'(ocrc_err), 136'(0));

    // ACMD41 with R3
    f = make_cmd(6'd41, $urandom);
    send_cmd(f);
    chk("acmd41_valid", 136'(ocmd_valid), 136'(1));
    chk("acmd41_arg", 136'(ocmd_arg), 136'(f[39:8]));
    respond("acmd41", 2, 2'd2, 127'h80FF8000, 6'd41, cap);
    chk("acmd41_crcfield", 136'(cap[95:89]), 136'(7'h7F));

    // CMD2 with R2
    send_cmd(make_cmd(6'd2, 32'd0));
    chk("cmd2_valid", 136'(ocmd_valid), 136'(1));
    respond("cmd2", 5, 2'd3, rand127(), 6'd2, cap);

    // no response -> timeout
    send_cmd(make_cmd(6'd13, 32'h0001_0000));
    chk("to_valid", 136'(ocmd_valid), 136'(1));
    respond("timeout", 0, 2'd1, '0, 6'd13, cap);
    step();
    chk("to_pulse", 136'(otimeout), 136'(0));
    last_idx = 6'd13;
    last_arg = 32'h0001_0000;

    // randomized commands, corruptions and responses
    for (int it = 0; it < 10; it++) begin
      logic [5:0]  ri;
      logic [31:0] ra;
      logic [1:0]  rt;
      int          rd;
      int          pos;
      bit          bad;
      ri  = 6'($urandom_range(0, 63));
      ra  = $urandom;
      f   = make_cmd(ri, ra);
      bad = ($urandom_range(0, 3) == 0);
      if (bad) begin
        pos = $urandom_range(1, 47);
        f[47 - pos] = ~f[47 - pos];
      end
      send_cmd(f);
      if (bad) begin
        chk("rnd_bad_err", 136'(ocrc_err), 136'(1));
        chk("rnd_bad_valid", 136'(ocmd_valid), 136'(0));
        chk("rnd_bad_index", 136'(ocmd_index), 136'(last_idx));
        chk("rnd_bad_arg", 136'(ocmd_arg), 136'(last_arg));
        step();
        chk("rnd_bad_busy", 136'(obusy), 136'(0));
      end else begin
        chk("rnd_valid", 136'(ocmd_valid), 136'(1));
        chk("rnd_index", 136'(ocmd_index), 136'(ri));
        chk("rnd_arg", 136'(ocmd_arg), 136'(ra));
        last_idx = ri;
        last_arg = ra;
        rt = 2'($urandom_range(0, 3));
        rd = $urandom_range(1, NCR_MAX + 4);
        respond("rnd", rd, rt, rand127(), ri, cap);
      end
      step();
    end

    // reset in the middle of an R2 response
    r2_data = rand127();
    send_cmd(make_cmd(6'd2, 32'd0));
    chk("r2rst_valid", 136'(ocmd_valid), 136'(1));
    iresp_valid = 1'b1;
    iresp_type  = 2'd3;
    iresp_data  = r2_data;
    step();
    iresp_valid = 1'b0;
    wait_n = 0;
    while (!ocmd_oe && wait_n < 20) begin
      step();
      wait_n++;
    end
    chk("r2rst_oe_on", 136'(ocmd_oe), 136'(1));
    repeat (20) step();
    chk("r2rst_mid_oe", 136'(ocmd_oe), 136'(1));
    #2 irst_n = 1'b0;
    #1;
    chk("r2rst_oe", 136'(ocmd_oe), 136'(0));
    chk("r2rst_sd", 136'(ocmd_sd), 136'(1));
    chk("r2rst_busy", 136'(obusy), 136'(0));
    chk("r2rst_index", 136'(ocmd_index), 136'(0));
    step();
    irst_n = 1'b1;
    step();
    chk("r2rst_oe_after", 136'(ocmd_oe), 136'(0));
    send_cmd(48'h40_0000_0000_95);
    chk("post_rst_valid", 136'(ocmd_valid), 136'(1));
    chk("post_rst_index", 136'(ocmd_index), 136'(0));
    chk("post_rst_arg", 136'(ocmd_arg), 136'(0));
    respond("post_rst", 2, 2'd0, '0, 6'd0, cap);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_cmd_responder.md
# sd_cmd_responder

Card-side endpoint of the SD CMD line: deserialises 48-bit host command frames, checks framing and CRC7, and hands index and argument to card logic. It then serialises the card logic's R1/R6, R3 or R2 response back onto CMD within the NCR window. It is used as the card model in the system bench and as the CMD front end of the card-emulation path. It runs on the SD clock driven by the host.

## Interface
- NCR, 2, minimum cycles from command end-bit sample to response start bit; legal range 2..NCR_MAX.
- NCR_MAX, 64, last edge (counted from end-bit sample) at which a response may still be accepted.
- iclk  in  1  SD clock; all sampling and driving on posedge.
- irst_n  in  1  one clock; reset is asynchronous and active-low.
- icmd_sd  in  1  CMD line, sampled.
- ocmd_sd  out  1  CMD line, driven value.
- ocmd_oe  out  1  CMD output enable.
- ocmd_valid  out  1  one-cycle pulse: good command received.
- ocmd_index  out  6  command index, held until the next good command.
- ocmd_arg  out  32  command argument, held until the next good command.
- ocrc_err  out  1  one-cycle pulse: CRC7 mismatch or bad transmission/end bit.
- otimeout  out  1  one-cycle pulse: no response accepted by NCR_MAX.
- iresp_valid  in  1  response offer from card logic.
- iresp_type  in  2  0 none, 1 R1/R6, 2 R3, 3 R2.
- iresp_data  in  127  payload; R1/R3 use [31:0]; R2 uses [126:0] (CID/CSD bits 127:1, internal CRC included).
- obusy  out  1  high whenever the FSM is not IDLE.

## Operation
- States: IDLE, RX, WAIT, TX.
- IDLE: icmd_sd sampled 0 → RX with bit counter = 1 and CRC seeded with the start bit.
- RX: shift 47 further bits. The CRC7 (x^7+x^3+1, init 0) covers bits 0..39. At the end-bit edge, a frame is good if transmission bit = 1, received CRC equals computed CRC, and end bit = 1.
  - Good frame: latch index/arg, pulse ocmd_valid, go to WAIT.
  - Bad frame: pulse ocrc_err, go to IDLE; no response is sent.
- WAIT: the first edge with iresp_valid latches type and data. Type 0 → IDLE silently. If nothing is accepted by edge E+NCR_MAX → pulse otimeout and go to IDLE.
- TX frame for R1: 0, 0, cmd index, data[31:0], CRC7 over the first 40 bits, 1.
- TX frame for R3: 0, 0, 111111, data[31:0], 1111111, 1.
- TX frame for R2: 0, 0, 111111, data[126:0], 1 (136 bits).
- TX → IDLE after the end bit; the line is released.
- iresp_valid outside WAIT is ignored. icmd_sd is ignored outside IDLE/RX.
- A 1 in IDLE keeps the FSM in IDLE. A command arriving while in WAIT or TX is not detected.
- Reset at any point, including mid-TX: state IDLE, ocmd_oe=0, and every other output 0 except ocmd_sd=1.

## Timing
- E = edge that samples the end bit (the start bit is sampled at edge E−47).
- ocmd_valid and ocrc_err are high in the cycle after E.
- Start bit on ocmd_sd with ocmd_oe=1 from edge E+NCR if the response was latched at or before E+NCR−1. Otherwise it appears at the edge after the latch.
- One bit per cycle. ocmd_oe stays high through the end bit and deasserts at the following edge, together with ocmd_sd=1.
- otimeout pulses in the cycle after E+NCR_MAX.
- R1 end bit is held for cycle S+47 and R2 for S+135 (S = start-bit cycle). IDLE resumes at the following edge.

## Structure
- sd_pkg holds: response type enum, frame lengths (48, 136), CRC7 polynomial, and the R3/R2 fixed index constant 6'b111111.
- Sub-module sd_crc7: bit-serial CRC7 with clear, enable, data-in and 7-bit output. Instantiate it twice, one for RX and one for TX.
- One FSM with a shared 8-bit bit counter and a 136-bit TX shift register.

## Test plan
- CMD0 frame 0x40_00000000_95 → ocmd_valid, index 0, arg 0; type 0 → no drive, obusy low after WAIT.
- CMD8 frame 0x48_000001AA_87 with R1 data 0x000001AA → response 0x08_000001AA_CRC, start bit at E+NCR.
- CMD17 frame 0x51_00000000_55 with R1 status 0x00000900 offered at E+10 → bits 0x11_00000900, CRC7 0x33, end 1, start at E+11.
- Same CMD17 frame with one argument bit flipped → ocrc_err pulse; no ocmd_valid; ocmd_oe stays 0.
- ACMD41 with R3 0x80FF8000 → CRC field 1111111. CMD2 with R2 pattern → 136 bits, oe for exactly 136 cycles.
- No iresp_valid → otimeout at E+NCR_MAX+1. Second case: irst_n pulsed mid-R2 → ocmd_oe=0 and ocmd_sd=1 immediately, then a following CMD0 is decoded normally.
